// File: rtl/vga_text_writer_if.sv
// Byte-stream input and VGA cell-write output bundle for vga_text_writer.
// The slave modport is the writer; the master modport is whoever feeds it bytes.
interface vga_text_writer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic [9:0] dataX;
    logic [9:0] dataY;
    logic       enter;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic       busy;

    modport slave (
        input  in_data, in_valid,
        output in_ready, data, dataX, dataY, enter, cur_x, cur_y, busy
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, data, dataX, dataY, enter, cur_x, cur_y, busy
    );
endinterface

// File: rtl/vga_text_writer.sv
// Text cursor and character decoder that drives VGA cell-write strobes.
// Define VGA_TEXT_WRITER_CLEAR_EN to make form feed (8'h0C) clear the whole screen.
module vga_text_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              CLK,
    input  logic              RST,
    vga_text_writer_if.slave  bus
);
    localparam logic [9:0] COLS_W = 10'(COLS);
    localparam logic [9:0] ROWS_W = 10'(ROWS);

`ifdef VGA_TEXT_WRITER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, WRITE} state_t;
`endif

    state_t     state_q, state_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic [7:0] data_q, data_d;
    logic [9:0] dx_q, dx_d;
    logic [9:0] dy_q, dy_d;
    logic       enter_q, enter_d;

    logic [9:0] adv_x;
    logic [9:0] adv_y;
    logic       printable;

    assign adv_x     = (cur_x_q < COLS_W) ? cur_x_q + 10'd1 : 10'd1;
    assign adv_y     = (cur_y_q < ROWS_W) ? cur_y_q + 10'd1 : 10'd1;
    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cur_x_q <= 10'd1;
            cur_y_q <= 10'd1;
            data_q  <= FILL_CHAR;
            dx_q    <= 10'd1;
            dy_q    <= 10'd1;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            data_q  <= data_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            enter_q <= enter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        data_d  = data_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        enter_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (printable) begin
                        data_d  = bus.in_data;
                        dx_d    = cur_x_q;
                        dy_d    = cur_y_q;
                        enter_d = 1'b1;
                        state_d = WRITE;
                        cur_x_d = adv_x;
                        if (cur_x_q >= COLS_W) begin
                            cur_y_d = adv_y;
                        end
                    end else if (bus.in_data == 8'h0D) begin
                        cur_x_d = 10'd1;
                    end else if (bus.in_data == 8'h0A) begin
                        cur_x_d = 10'd1;
                        cur_y_d = adv_y;
                    end else if (bus.in_data == 8'h08) begin
                        // Backspace stops at column 1 rather than wrapping to the previous row.
                        if (cur_x_q > 10'd1) begin
                            cur_x_d = cur_x_q - 10'd1;
                            data_d  = FILL_CHAR;
                            dx_d    = cur_x_q - 10'd1;
                            dy_d    = cur_y_q;
                            enter_d = 1'b1;
                            state_d = WRITE;
                        end
`ifdef VGA_TEXT_WRITER_CLEAR_EN
                    end else if (bus.in_data == 8'h0C) begin
                        data_d  = FILL_CHAR;
                        dx_d    = 10'd1;
                        dy_d    = 10'd1;
                        enter_d = 1'b1;
                        state_d = CLEAR;
`endif
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
`ifdef VGA_TEXT_WRITER_CLEAR_EN
            CLEAR: begin
                // The output coordinate registers double as the sweep position.
                if ((dx_q == COLS_W) && (dy_q == ROWS_W)) begin
                    state_d = IDLE;
                    cur_x_d = 10'd1;
                    cur_y_d = 10'd1;
                end else begin
                    enter_d = 1'b1;
                    if (dx_q < COLS_W) begin
                        dx_d = dx_q + 10'd1;
                    end else begin
                        dx_d = 10'd1;
                        dy_d = dy_q + 10'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready = (state_q == IDLE) & ~RST;
    assign bus.busy     = (state_q != IDLE);
    assign bus.data     = data_q;
    assign bus.dataX    = dx_q;
    assign bus.dataY    = dy_q;
    assign bus.enter    = enter_q;
    assign bus.cur_x    = cur_x_q;
    assign bus.cur_y    = cur_y_q;
endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
- Producer end of the VGA character-write interface (data / dataX / dataY / enter) that the VGA text renderer consumes.
- Accepts a byte stream over a valid/ready handshake and keeps a text cursor.
- Interprets printable ASCII and basic control codes, and issues one-cycle cell-write strobes at 1-based cell coordinates.
- Replaces the free-running character counter in top as the source of screen writes.

Parameters:
- COLS, 80, columns per screen; valid dataX range 1..COLS.
- ROWS, 30, rows per screen; valid dataY range 1..ROWS.
- FILL_CHAR, 8'h20, character written by backspace and by clear.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_data  in  8  input character byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a byte; combinational: (state==IDLE) & ~RST.
- data  out  8  character code to write into the VGA cell.
- dataX  out  10  target column, 1-based.
- dataY  out  10  target row, 1-based.
- enter  out  1  one-cycle write strobe; data/dataX/dataY are valid while it is high.
- cur_x  out  10  current cursor column, 1-based.
- cur_y  out  10  current cursor row, 1-based.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset, asynchronous, applied immediately, any state:
  - state=IDLE, enter=0, data=FILL_CHAR, dataX=1, dataY=1, cur_x=1, cur_y=1, busy=0, in_ready=0 while RST is high.
  - Reset during WRITE or CLEAR aborts the operation; no further enter pulses follow.
- States: IDLE, WRITE, CLEAR (CLEAR exists only with the optional feature).
- Accept: in_valid & in_ready on edge N. The byte is decoded at that edge.
- Printable byte (8'h20..8'h7E):
  - Edge N: data<=byte, dataX<=cur_x, dataY<=cur_y, enter<=1, state<=WRITE, cursor advances.
  - Edge N+1: enter<=0, state<=IDLE.
  - Latency: enter is high for exactly the cycle after acceptance.
  - Throughput: 1 byte per 2 cycles; in_ready is low in WRITE.
- Cursor advance:
  - cur_x+1 if cur_x<COLS.
  - Otherwise cur_x=1 and cur_y+1 if cur_y<ROWS, else cur_y=1 (wrap to top, no scroll).
- 8'h0D (CR): cur_x<=1; no write; stays IDLE, so the next byte can be accepted the following cycle.
- 8'h0A (LF): cur_x<=1, cur_y advances with the same wrap rule; no write.
- 8'h08 (BS):
  - If cur_x>1: cur_x<=cur_x-1 and write FILL_CHAR at the new position (same 2-cycle WRITE sequence).
  - If cur_x==1: no cursor change and no write. Backspace does not cross rows.
- Any other byte is consumed and ignored; no state or cursor change.
- data/dataX/dataY hold their last values when enter=0.
- in_valid while in_ready=0 is not accepted; the upstream block must hold in_data/in_valid until ready.
- Arithmetic: 10-bit unsigned; COLS, ROWS <= 1023; the cursor never leaves 1..COLS / 1..ROWS.

Optional Feature:
- Macro: VGA_TEXT_WRITER_CLEAR_EN.
- Defined: 8'h0C (FF) is accepted and enters CLEAR.
  - Emits COLS*ROWS back-to-back enter pulses, one per cycle, with data=FILL_CHAR, row-major from (1,1) to (COLS,ROWS).
  - On the edge after the last pulse: enter<=0, cur_x=cur_y=1, state<=IDLE.
  - in_ready=0 and busy=1 throughout CLEAR.
- Not defined: 8'h0C is treated as an unrecognised byte (consumed, ignored), and no CLEAR state or counters are synthesised.

Test Plan:
- COLS=10, ROWS=10; after reset send 'A' (8'h41) -> enter=1 for exactly one cycle after acceptance with data=8'h41, dataX=1, dataY=1; then cur_x=2, in_ready low for that cycle only.
- Send 10 printable bytes from (1,1) -> the 10th writes at (10,1); cursor becomes (1,2). Starting at (10,10), one byte -> cursor wraps to (1,1).
- Cursor (5,3): send CR -> cursor (1,3), no enter. Send LF from (5,10) -> cursor (1,1), no enter.
- Cursor (4,2): send BS -> enter with data=8'h20 at (3,2), cursor (3,2). Cursor (1,2): send BS -> no enter, cursor unchanged.
- CLEAR_EN defined, COLS=ROWS=10: send FF -> exactly 100 consecutive enter pulses from (1,1) to (10,10), data=8'h20, then cursor (1,1), in_ready high.
  - Assert RST at pulse 40 -> enter drops immediately, outputs take reset values, and no further pulses follow.
- Hold in_valid high with 8'h7F -> byte consumed every cycle, with no enter and no cursor change.
